// File: rtl/rotation_rate_ctrl_pkg.sv
// Shared types and constants for the rotating-square animator control stage.
package rotation_pkg;

   // Debouncer states; the debounced level is 1 in ONE and WAIT0.
   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_t;

   // Rate index limits: 0 is the slowest step rate, 3 the fastest.
   localparam logic [1:0] SPEED_MIN   = 2'd0;
   localparam logic [1:0] SPEED_MAX   = 2'd3;
   localparam logic [1:0] SPEED_RESET = 2'd0;

endpackage

// File: rtl/rotation_rate_ctrl_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, four-state debouncer and a
// one-cycle press pulse issued only on the ZERO->WAIT1->ONE path, so a held
// button yields one press and a new press needs a full release first.
module btn_debounce
   import rotation_pkg::*;
#(
   parameter int DB_CNT = 1_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic press
);

   localparam int CNT_W = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
   localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DB_CNT - 1);

   logic [1:0]       sync_r;
   logic             sync_s;
   db_state_t        state_r;
   db_state_t        state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             enter_one_s;
   logic             press_r;

   assign sync_s = sync_r[1];
   assign press  = press_r;

   // Bring the asynchronous button into the clk domain.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= 2'b00;
      end else begin
         sync_r <= {sync_r[0], btn_raw};
      end
   end

   // Debouncer state, stability counter and registered press pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ZERO;
         cnt_r   <= '0;
         press_r <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         press_r <= enter_one_s;
      end
   end

   // Next-state logic: a level change is accepted only after DB_CNT stable cycles.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      enter_one_s = 1'b0;
      case (state_r)
         ZERO: begin
            if (sync_s) begin
               state_nxt_s = WAIT1;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ZERO;
            end
         end
         WAIT1: begin
            if (!sync_s) begin
               state_nxt_s = ZERO;
            end else if (cnt_r == CNT_TERM) begin
               state_nxt_s = ONE;
               enter_one_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         ONE: begin
            if (!sync_s) begin
               state_nxt_s = WAIT0;
               cnt_nxt_s   = '0;
            end else begin
               state_nxt_s = ONE;
            end
         end
         WAIT0: begin
            if (sync_s) begin
               state_nxt_s = ONE;
            end else if (cnt_r == CNT_TERM) begin
               state_nxt_s = ZERO;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         default: begin
            state_nxt_s = ZERO;
            cnt_nxt_s   = '0;
         end
      endcase
   end

endmodule

// File: rtl/rotation_rate_ctrl.sv
// Control stage for the rotating-square animator: debounced pause/speed
// buttons, run/pause and rate registers, and the prescaler that emits one
// step pulse per animation step.
module rotation_rate_ctrl
   import rotation_pkg::*;
#(
   parameter int DB_CNT   = 1_000_000,
   parameter int BASE_DIV = 12_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_pause,
   input  logic       btn_speed,
   output logic       step,
   output logic       running,
   output logic [1:0] speed
);

   // Wide enough for the slowest period, 8*BASE_DIV.
   localparam int PS_W = $clog2(8 * BASE_DIV);
   localparam logic [PS_W-1:0] TERM0 = PS_W'(8 * BASE_DIV - 1);
   localparam logic [PS_W-1:0] TERM1 = PS_W'(4 * BASE_DIV - 1);
   localparam logic [PS_W-1:0] TERM2 = PS_W'(2 * BASE_DIV - 1);
   localparam logic [PS_W-1:0] TERM3 = PS_W'(BASE_DIV - 1);

   logic            pause_press_s;
   logic            speed_press_s;
   logic            clear_s;
   logic [PS_W-1:0] term_s;
   logic            running_r;
   logic [1:0]      speed_r;
   logic [PS_W-1:0] count_r;
   logic            step_r;

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_pause (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_pause),
      .press   (pause_press_s)
   );

   btn_debounce #(.DB_CNT(DB_CNT)) u_db_speed (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (btn_speed),
      .press   (speed_press_s)
   );

   // Any press restarts the period so a rate change never produces a short step.
   assign clear_s = pause_press_s | speed_press_s;

   assign step    = step_r;
   assign running = running_r;
   assign speed   = speed_r;

   // Terminal count P-1 for the current rate, P = BASE_DIV << (3-speed).
   always_comb begin
      term_s = TERM0;
      case (speed_r)
         2'd0:    term_s = TERM0;
         2'd1:    term_s = TERM1;
         2'd2:    term_s = TERM2;
         2'd3:    term_s = TERM3;
         default: term_s = TERM0;
      endcase
   end

   // Run/pause and rate registers, updated the cycle after a press.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         running_r <= 1'b1;
         speed_r   <= SPEED_RESET;
      end else begin
         if (pause_press_s) begin
            running_r <= ~running_r;
         end
         if (speed_press_s) begin
            speed_r <= (speed_r == SPEED_MAX) ? SPEED_MIN : speed_r + 2'd1;
         end
      end
   end

   // Prescaler: a press clear wins over the terminal count; paused holds the count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_r <= '0;
         step_r  <= 1'b0;
      end else if (clear_s) begin
         count_r <= '0;
         step_r  <= 1'b0;
      end else if (running_r) begin
         if (count_r == term_s) begin
            count_r <= '0;
            step_r  <= 1'b1;
         end else begin
            count_r <= count_r + PS_W'(1);
            step_r  <= 1'b0;
         end
      end else begin
         step_r <= 1'b0;
      end
   end

endmodule
